// File: rtl/u_stream_reader_if.sv
// Column stream from the unmixing-array drain to the nonlinearity stage.
// One column of three scaled samples per transfer, valid/ready handshake.
interface u_stream_reader_if #(
  parameter int N_SAMP = 64,
  parameter int OW     = 16
);
  localparam int IW = $clog2(N_SAMP);

  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_u0;
  logic signed [OW-1:0] out_u1;
  logic signed [OW-1:0] out_u2;
  logic [IW-1:0]        out_idx;
  logic                 out_last;

  modport master (
    output out_valid, out_u0, out_u1, out_u2, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_u0, out_u1, out_u2, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/u_stream_reader.sv
// Drain side of the unmixing array: snapshots the 3 x N_SAMP product
// matrix after the array latency, rescales each element to OW bits with
// round-half-up and saturation, and streams it out one column per transfer.

// Per-lane rescale: drop SHIFT fractional bits with rounding toward +inf
// at the half point, then clamp to the signed OW-bit range.
module u_stream_scale #(
  parameter int SHIFT = 12,
  parameter int OW    = 16
) (
  input  logic [31:0]          v,
  output logic signed [OW-1:0] q
);
  // 33-bit working width keeps the rounding add from wrapping at +max.
  localparam logic signed [32:0] RND  = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OW - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OW - 1));

  logic signed [32:0] sum;
  logic signed [32:0] r;

  // Round, shift, saturate.
  always_comb begin
    sum = $signed({v[31], v}) + RND;
    r   = sum >>> SHIFT;
    if (r > MAXV)      q = MAXV[OW-1:0];
    else if (r < MINV) q = MINV[OW-1:0];
    else               q = r[OW-1:0];
  end
endmodule

module u_stream_reader #(
  parameter int N_SAMP = 64,
  parameter int LAT    = 2,
  parameter int SHIFT  = 12,
  parameter int OW     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [0:2][0:N_SAMP-1][31:0]    u,
  u_stream_reader_if.master               os,
  output logic                            busy,
  output logic                            done
);
  localparam int IW = $clog2(N_SAMP);
  localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [WW-1:0] WLAST    = WW'(LAT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_SAMP - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                     state;
  logic [WW-1:0]                  wcnt;
  logic [IW-1:0]                  idx;
  logic [IW-1:0]                  nidx;
  logic                           vld;
  logic [0:2][OW-1:0]             oq;
  logic [0:2][0:N_SAMP-1][31:0]   snap;
  logic [0:2][31:0]               lane_v;
  logic [0:2][OW-1:0]             lane_q;
  logic                           cap;
  logic                           xfer;

  assign cap  = (state == S_WAIT) && (wcnt == WLAST);
  assign xfer = vld && os.out_ready;
  assign nidx = idx + 1'b1;

  // Column 0 is scaled straight off the array at capture so it is ready on
  // the same edge; later columns come from the snapshot one index ahead.
  always_comb begin
    lane_v = '0;
    for (int r = 0; r < 3; r++)
      lane_v[r] = cap ? u[r][0] : snap[r][nidx];
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    u_stream_scale #(.SHIFT(SHIFT), .OW(OW)) u_scale (
      .v (lane_v[g]),
      .q (lane_q[g])
    );
  end

  // Snapshot of the whole matrix, taken only at the capture edge; not reset.
  always_ff @(posedge clk)
    if (cap) snap <= u;

  // Block sequencer and output column registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      wcnt  <= '0;
      idx   <= '0;
      vld   <= 1'b0;
      oq    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            wcnt  <= '0;
          end
        end
        S_WAIT: begin
          if (cap) begin
            oq    <= lane_q;
            vld   <= 1'b1;
            idx   <= '0;
            state <= S_STREAM;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              vld   <= 1'b0;
              state <= S_DONE;
            end else begin
              idx <= nidx;
              oq  <= lane_q;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign os.out_valid = vld;
  assign os.out_u0    = oq[0];
  assign os.out_u1    = oq[1];
  assign os.out_u2    = oq[2];
  assign os.out_idx   = idx;
  assign os.out_last  = vld && (idx == IDX_LAST);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
endmodule

// File: tb/tb_u_stream_reader.sv
// Bench for u_stream_reader: table vectors for rounding/saturation, ramp,
// backpressure, snapshot isolation, ignored starts, mid-stream reset and
// random blocks checked against a plain-arithmetic scaling model.
module tb_u_stream_reader;
  localparam int N = 64, LAT = 2, SHIFT = 12, OW = 16;

  logic clk = 0, reset = 1, start = 0;
  logic [0:2][0:N-1][31:0] u;
  logic busy, done;
  int checks = 0, failures = 0;
  longint expq [3][N];

  typedef struct { logic [31:0] v; longint q; } vec_t;
  vec_t tbl [7];

  u_stream_reader_if #(.N_SAMP(N), .OW(OW)) os ();

  u_stream_reader #(.N_SAMP(N), .LAT(LAT), .SHIFT(SHIFT), .OW(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .u(u), .os(os),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: floor((v + 2^(SHIFT-1)) / 2^SHIFT), clamped to OW bits.
  function automatic longint scale_ref(input logic [31:0] v);
    longint x, lo, hi;
    x  = longint'($signed(v));
    x  = (x + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    if (x > hi) x = hi;
    if (x < lo) x = lo;
    return x;
  endfunction

  task automatic fill_rand();
    int k;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++) begin
        case ($urandom % 3)
          0: u[r][c] = $urandom;
          1: u[r][c] = 32'($urandom_range(0, 1 << 28)) - 32'(1 << 27);
          default: begin
            k = int'($urandom_range(0, 40000)) - 20000;
            u[r][c] = 32'(k * 4096 + 2048);
          end
        endcase
      end
  endtask

  // Entered and left on a falling edge. rmode: 0 ready=1, 1 pattern 1,0,0,1,
  // 2 random. abort_at >= 0 asserts reset when that index is presented.
  task automatic run_block(input int rmode, input bit probe, input bit clobber,
                           input int abort_at, input bit use_tbl);
    int exp_idx, cyc;
    bit fin, stalled, rdy;
    longint p0, p1, p2, pidx;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++)
        expq[r][c] = (use_tbl && c < 7) ? tbl[c].q : scale_ref(u[r][c]);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("valid_early", os.out_valid, 0);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk("valid_early", os.out_valid, 0);
    end
    @(negedge clk);
    if (clobber) u = '1;
    exp_idx = 0; cyc = 0; fin = 0; stalled = 0;
    p0 = 0; p1 = 0; p2 = 0; pidx = 0;
    while (!fin && cyc < 1000) begin
      if (cyc == 0) chk("latency_valid", os.out_valid, 1);
      if (abort_at >= 0 && os.out_valid && int'(os.out_idx) == abort_at) begin
        reset = 0;
        #1;
        chk("rst_valid", os.out_valid, 0);
        chk("rst_u0", os.out_u0, 0);
        chk("rst_u1", os.out_u1, 0);
        chk("rst_u2", os.out_u2, 0);
        chk("rst_idx", os.out_idx, 0);
        chk("rst_last", os.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", done, 0);
          chk("rst_hold_valid", os.out_valid, 0);
        end
        reset = 1;
        return;
      end
      if (os.out_valid) begin
        chk("idx", os.out_idx, exp_idx);
        chk("u0", os.out_u0, expq[0][exp_idx]);
        chk("u1", os.out_u1, expq[1][exp_idx]);
        chk("u2", os.out_u2, expq[2][exp_idx]);
        chk("last", os.out_last, longint'(exp_idx == N - 1));
        if (stalled) begin
          chk("stall_u0", os.out_u0, p0);
          chk("stall_u1", os.out_u1, p1);
          chk("stall_u2", os.out_u2, p2);
          chk("stall_idx", os.out_idx, pidx);
        end
        case (rmode)
          0: rdy = 1;
          1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: rdy = ($urandom % 3) != 0;
        endcase
        os.out_ready = rdy;
        start = probe && exp_idx == 10;
        stalled = !rdy;
        p0 = os.out_u0; p1 = os.out_u1; p2 = os.out_u2; pidx = os.out_idx;
        if (rdy) begin
          if (exp_idx == N - 1) fin = 1;
          exp_idx++;
        end
      end else begin
        chk("valid_dropped", os.out_valid, 1);
        cyc = 1000;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (!fin) chk("stream_timeout", 0, 1);
    chk("transfers", exp_idx, N);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("valid_after_last", os.out_valid, 0);
    chk("last_after_last", os.out_last, 0);
    if (probe) start = 1;
    @(negedge clk);
    start = 0;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    os.out_ready = 0;
    u = '0;
    #2 reset = 0;
    #1;
    chk("reset_valid", os.out_valid, 0);
    chk("reset_u0", os.out_u0, 0);
    chk("reset_u1", os.out_u1, 0);
    chk("reset_u2", os.out_u2, 0);
    chk("reset_idx", os.out_idx, 0);
    chk("reset_last", os.out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);

    tbl[0] = '{32'd2048, 1};
    tbl[1] = '{32'hFFFFF800, 0};
    tbl[2] = '{32'd6143, 1};
    tbl[3] = '{32'hFFFFE7FF, -2};
    tbl[4] = '{32'h7FFFFFFF, 32767};
    tbl[5] = '{32'h80000000, -32768};
    tbl[6] = '{32'd134213632, 32767};

    // Ramp, ready tied high.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++)
        u[r][c] = 32'((c + 1) * 4096 * (r + 1));
    run_block(0, 0, 0, -1, 0);

    // Rounding / saturation vectors in columns 0..6, random elsewhere.
    fill_rand();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 7; c++)
        u[r][c] = tbl[c].v;
    run_block(0, 0, 0, -1, 1);

    // Backpressure pattern.
    fill_rand();
    run_block(1, 0, 0, -1, 0);

    // Snapshot isolation: u overwritten right after capture.
    fill_rand();
    run_block(2, 0, 1, -1, 0);

    // Starts ignored mid-stream and in DONE, then an immediate new block.
    fill_rand();
    run_block(0, 1, 0, -1, 0);
    fill_rand();
    run_block(2, 0, 0, -1, 0);

    // Reset mid-stream at idx 30, then a fresh block from idx 0.
    fill_rand();
    run_block(0, 0, 0, 30, 0);
    @(negedge clk);
    fill_rand();
    run_block(1, 0, 0, -1, 0);

    repeat (3) begin
      fill_rand();
      run_block(2, 0, 0, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
